ft_rom_bridge: RTL and testbench

FT_ROM_BRIDGE -- requirements
Module: ft_rom_bridge

---
 rtl/ft_rom_bridge.sv | 189 ++++++++++++++++++
 tb/tb_ft_rom_bridge.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ft_rom_bridge.sv
// Bridges a command/response FIFO pair to an FT245 sync-FIFO host: sends one address
// frame to the host, reads one data frame back and pushes it to the response FIFO.
module ft_rom_bridge #(
    parameter int FRAME_BYTES = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic       ft_clk,
    input  logic       rst_n,
    input  logic       cmd_empty,
    output logic       cmd_rd_en,
    input  logic [7:0] cmd_dout,
    input  logic       rsp_full,
    output logic       rsp_wr_en,
    output logic [7:0] rsp_din,
    input  logic       ft_txe_n,
    input  logic       ft_rxf_n,
    output logic       ft_wr_n,
    output logic       ft_rd_n,
    output logic       ft_oe_n,
    input  logic [7:0] ft_data_i,
    output logic [7:0] ft_data_o,
    output logic       ft_data_oe,
    output logic       busy,
    output logic       err
);

    localparam int IW = $clog2(FRAME_BYTES) + 1;
    localparam int AW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IW-1:0] LAST   = IW'(FRAME_BYTES - 1);
    localparam logic [IW-1:0] FULL   = IW'(FRAME_BYTES);
    localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);
    localparam bit            TO_EN  = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_TX, S_RXOE, S_RX, S_PUSH
    } state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [IW-1:0] iss, iss_nx;
    logic [TW-1:0] to_cnt, to_nx;
    logic [AW-1:0] idx_a;
    logic          cmd_vld_p1;
    logic [7:0]    frame_buf [FRAME_BYTES];

    logic          buf_wr;
    logic          buf_fill;
    logic [7:0]    buf_wdata;
    logic          to_tick;

    assign idx_a = idx[AW-1:0];
    assign busy  = (state != S_IDLE);

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        iss_nx     = iss;
        to_nx      = to_cnt;
        cmd_rd_en  = 1'b0;
        rsp_wr_en  = 1'b0;
        rsp_din    = 8'h00;
        ft_wr_n    = 1'b1;
        ft_rd_n    = 1'b1;
        ft_oe_n    = 1'b1;
        ft_data_o  = 8'h00;
        ft_data_oe = 1'b0;
        err        = 1'b0;
        buf_wr     = 1'b0;
        buf_fill   = 1'b0;
        buf_wdata  = 8'h00;
        to_tick    = 1'b0;

        case (state)
            S_IDLE: begin
                idx_nx = '0;
                iss_nx = '0;
                if (!cmd_empty) state_nx = S_CMD;
            end
            S_CMD: begin
                // Pops run one cycle ahead of captures; cmd_vld_p1 marks a byte on cmd_dout.
                cmd_rd_en = !cmd_empty && (iss < FULL);
                if (cmd_rd_en) iss_nx = iss + 1'b1;
                if (cmd_vld_p1) begin
                    buf_wr    = 1'b1;
                    buf_wdata = cmd_dout;
                    if (idx == LAST) begin
                        idx_nx   = '0;
                        to_nx    = '0;
                        state_nx = S_TX;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            S_TX: begin
                ft_data_oe = 1'b1;
                ft_data_o  = frame_buf[idx_a];
                ft_wr_n    = ft_txe_n;
                if (!ft_txe_n) begin
                    to_nx = '0;
                    if (idx == LAST) begin
                        idx_nx   = '0;
                        state_nx = S_RXOE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    to_tick = 1'b1;
                end
            end
            S_RXOE: begin
                // Bus already released; OE leads RD by at least one cycle.
                ft_oe_n = ft_rxf_n;
                if (!ft_rxf_n) begin
                    to_nx    = '0;
                    state_nx = S_RX;
                end else begin
                    to_tick = 1'b1;
                end
            end
            S_RX: begin
                ft_oe_n = 1'b0;
                ft_rd_n = ft_rxf_n;
                if (!ft_rxf_n) begin
                    buf_wr    = 1'b1;
                    buf_wdata = ft_data_i;
                    to_nx     = '0;
                    if (idx == LAST) begin
                        idx_nx   = '0;
                        state_nx = S_PUSH;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end else begin
                    to_tick = 1'b1;
                end
            end
            S_PUSH: begin
                rsp_din   = frame_buf[idx_a];
                rsp_wr_en = !rsp_full;
                if (rsp_wr_en) begin
                    if (idx == LAST) begin
                        idx_nx   = '0;
                        state_nx = S_IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // A stalled host still yields a full frame of FF so upstream always gets a reply.
        if (to_tick) begin
            if (TO_EN && (to_cnt >= TO_LIM)) begin
                err      = 1'b1;
                buf_fill = 1'b1;
                idx_nx   = '0;
                state_nx = S_PUSH;
            end else begin
                to_nx = to_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge ft_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idx        <= '0;
            iss        <= '0;
            to_cnt     <= '0;
            cmd_vld_p1 <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) frame_buf[i] <= 8'h00;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            iss        <= iss_nx;
            to_cnt     <= to_nx;
            cmd_vld_p1 <= cmd_rd_en;
            if (buf_fill) begin
                for (int i = 0; i < FRAME_BYTES; i++) frame_buf[i] <= 8'hFF;
            end else if (buf_wr) begin
                frame_buf[idx_a] <= buf_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ft_rom_bridge.sv
// Scoreboard bench for ft_rom_bridge: FIFO and FTDI host models, expected bytes queued by
// the stimulus and popped by an independent monitor.
module tb_ft_rom_bridge;

    logic       ft_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_empty = 1'b1;
    logic       cmd_rd_en;
    logic [7:0] cmd_dout = 8'h00;
    logic       rsp_full = 1'b0;
    logic       rsp_wr_en;
    logic [7:0] rsp_din;
    logic       ft_txe_n = 1'b1;
    logic       ft_rxf_n = 1'b1;
    logic       ft_wr_n, ft_rd_n, ft_oe_n;
    logic [7:0] ft_data_i = 8'h00;
    logic [7:0] ft_data_o;
    logic       ft_data_oe;
    logic       busy;
    logic       err;

    ft_rom_bridge #(.FRAME_BYTES(8), .TIMEOUT_CYC(16)) dut (
        .ft_clk(ft_clk), .rst_n(rst_n),
        .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en), .cmd_dout(cmd_dout),
        .rsp_full(rsp_full), .rsp_wr_en(rsp_wr_en), .rsp_din(rsp_din),
        .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
        .ft_wr_n(ft_wr_n), .ft_rd_n(ft_rd_n), .ft_oe_n(ft_oe_n),
        .ft_data_i(ft_data_i), .ft_data_o(ft_data_o), .ft_data_oe(ft_data_oe),
        .busy(busy), .err(err)
    );

    always #5 ft_clk = ~ft_clk;

    logic [7:0] cmd_q[$], host_q[$], exp_tx[$], exp_rsp[$];
    int         gap_q[$];
    int         n_vec = 0, n_miss = 0;
    int         cyc = 0, tx_cnt = 0, push_cnt = 0, err_cnt = 0;
    int         last_wr_cyc = 0, err_cyc = 0, idle_run = 0;
    bit         flow = 0, silent = 0;
    bit         pop_pend = 0, prev_oe_n = 1, prev_busy = 0;
    logic [7:0] popped = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO and host models: inputs change on the falling edge, DUT requests sampled 1 ns later.
    always @(negedge ft_clk) begin
        bit phase;
        cyc++;
        if (!rst_n) begin
            cmd_q.delete();
            host_q.delete();
            pop_pend = 0;
        end
        if (pop_pend) begin
            cmd_dout = popped;
            pop_pend = 0;
        end
        phase     = flow && (((cyc / 3) % 2) == 1);
        cmd_empty = (cmd_q.size() == 0) || phase;
        ft_txe_n  = phase;
        ft_rxf_n  = silent || (host_q.size() == 0) || phase;
        rsp_full  = flow && (((cyc / 3) % 2) == 0);
        ft_data_i = (host_q.size() != 0) ? host_q[0] : 8'h00;
        #1;
        if (cmd_rd_en && cmd_q.size() != 0) begin
            popped   = cmd_q.pop_front();
            pop_pend = 1;
        end
        if (!ft_rd_n && host_q.size() != 0) void'(host_q.pop_front());
    end

    // Monitor: pops expectations whenever the DUT strobes a byte out.
    always @(negedge ft_clk) begin
        #1;
        if (!rst_n) begin
            exp_tx.delete();
            exp_rsp.delete();
            prev_oe_n = 1;
        end else begin
            if (!ft_wr_n) begin
                tx_cnt++;
                last_wr_cyc = cyc;
                chk("tx_bus_driven", ft_data_oe, 1'b1);
                chk("wr_exclusive", {ft_rd_n, ft_oe_n}, 2'b11);
                if (exp_tx.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL tx_extra: got %02h, expected no write", ft_data_o);
                end else chk("tx_byte", ft_data_o, exp_tx.pop_front());
            end
            if (rsp_wr_en) begin
                push_cnt++;
                if (exp_rsp.size() == 0) begin
                    n_vec++; n_miss++;
                    $display("FAIL rsp_extra: got %02h, expected no push", rsp_din);
                end else chk("rsp_byte", rsp_din, exp_rsp.pop_front());
            end
            if (!ft_rd_n) chk("oe_before_rd", prev_oe_n, 1'b0);
            if (!ft_oe_n) chk("bus_released_rx", ft_data_oe, 1'b0);
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            prev_oe_n = ft_oe_n;
        end
        if (!busy) idle_run++;
        else begin
            if (!prev_busy) gap_q.push_back(idle_run);
            idle_run = 0;
        end
        prev_busy = busy;
    end

    task automatic send_frame(input logic [63:0] cmd, input logic [63:0] host, input bit to_ff);
        for (int i = 0; i < 8; i++) begin
            cmd_q.push_back(cmd[8*i +: 8]);
            exp_tx.push_back(cmd[8*i +: 8]);
            if (to_ff) exp_rsp.push_back(8'hFF);
            else begin
                host_q.push_back(host[8*i +: 8]);
                exp_rsp.push_back(host[8*i +: 8]);
            end
        end
    endtask

    task automatic wait_done(input string name, input int base_push, input int frames);
        for (int i = 0; i < 3000; i++) begin
            @(negedge ft_clk);
            #2;
            if (exp_tx.size() == 0 && exp_rsp.size() == 0 && !busy) break;
        end
        chk({name, "_drained"}, {exp_tx.size() == 0, exp_rsp.size() == 0, busy}, 3'b110);
        chk({name, "_push_count"}, push_cnt - base_push, 8 * frames);
    endtask

    initial begin
        int b, g;
        repeat (3) @(negedge ft_clk);
        #2;
        chk("rst_cmd_rd_en", cmd_rd_en, 0);
        chk("rst_rsp_wr_en", rsp_wr_en, 0);
        chk("rst_rsp_din", rsp_din, 0);
        chk("rst_strobes", {ft_wr_n, ft_rd_n, ft_oe_n}, 3'b111);
        chk("rst_data_oe", ft_data_oe, 0);
        chk("rst_data_o", ft_data_o, 0);
        chk("rst_busy_err", {busy, err}, 2'b00);
        rst_n = 1;

        // Nominal frame
        b = push_cnt;
        send_frame(64'hEFCD_AB89_6745_2301, 64'h0123_4567_89AB_CDEF, 0);
        wait_done("nominal", b, 1);

        // Flow control on every handshake
        flow = 1;
        b = push_cnt;
        send_frame(64'h0123_4567_89AB_CDEF, 64'h5566_7788_99AA_BBCC, 0);
        wait_done("flow", b, 1);
        flow = 0;

        // Silent host: timeout returns a frame of FF
        silent = 1;
        b = push_cnt;
        g = err_cnt;
        send_frame(64'h1020_3040_5060_7080, 64'h0, 1);
        wait_done("timeout", b, 1);
        chk("timeout_err_pulses", err_cnt - g, 1);
        chk("timeout_err_delay", err_cyc - last_wr_cyc, 17);
        silent = 0;

        // Reset after three transmitted bytes
        b = tx_cnt;
        send_frame(64'hA7A6_A5A4_A3A2_A1A0, 64'hB7B6_B5B4_B3B2_B1B0, 0);
        for (int i = 0; i < 200; i++) begin
            @(negedge ft_clk);
            #2;
            if (tx_cnt >= b + 3) break;
        end
        chk("midtx_reached", tx_cnt - b, 3);
        @(posedge ft_clk);
        #1;
        rst_n = 0;
        #1;
        chk("midtx_rst_strobes", {ft_wr_n, ft_rd_n, ft_oe_n, ft_data_oe}, 4'b1110);
        chk("midtx_rst_fifo", {cmd_rd_en, rsp_wr_en, busy}, 3'b000);
        repeat (2) @(negedge ft_clk);
        #2;
        rst_n = 1;
        b = push_cnt;
        send_frame(64'h8877_6655_4433_2211, 64'h1122_3344_5566_7788, 0);
        wait_done("after_reset", b, 1);

        // Three queued frames back to back
        b = push_cnt;
        g = gap_q.size();
        send_frame(64'hEFCD_AB89_6745_2301, 64'hF0E1_D2C3_B4A5_9687, 0);
        send_frame(64'h0123_4567_89AB_CDEF, 64'h7869_5A4B_3C2D_1E0F, 0);
        send_frame(64'hAABB_CCDD_EEFF_0011, 64'h0F0F_F0F0_3C3C_C3C3, 0);
        wait_done("b2b", b, 3);
        chk("b2b_busy_periods", gap_q.size() - g, 3);
        for (int k = 1; k < 3; k++)
            chk("b2b_idle_gap", (gap_q.size() > g + k) ? gap_q[g + k] : -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
